// File: rtl/rssb_pkg.sv
// ============================================================================
// Module      : rssb_pkg
// Description : Shared states and constants for the RSSB one-instruction core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rssb_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [15:0] ADDR_IP   = 16'd0;
  localparam logic [15:0] ADDR_ACC  = 16'd1;
  localparam logic [15:0] ADDR_ZERO = 16'd2;
  localparam logic [15:0] ADDR_IN   = 16'd3;
  localparam logic [15:0] ADDR_OUT  = 16'd4;
  localparam logic [15:0] RESET_IP  = 16'h0005;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  // Operands 0..2 are register aliases, never real memory cells.
  function automatic logic is_special(input logic [15:0] a);
    return (a <= ADDR_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rssb_alu.sv
// ============================================================================
// Module      : rssb_alu
// Description : Reverse-subtract unit: r = m - acc with unsigned borrow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rssb_alu (
  input  logic [15:0] m,
  input  logic [15:0] acc,
  output logic [15:0] r,
  output logic        borrow
);

  logic [16:0] w_diff;

  // The extra bit goes high exactly when m < acc.
  assign w_diff = {1'b0, m} - {1'b0, acc};
  assign r      = w_diff[15:0];
  assign borrow = w_diff[16];

endmodule

`default_nettype wire

// File: rtl/rssb_core.sv
// ============================================================================
// Module      : rssb_core
// Description : Three-cycle RSSB processor core on a shared tri-state bus.
//               Config macro RSSB_IO_EN maps operands 3/4 to in/out ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rssb_core
  import rssb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  inout  wire  [15:0] data,
  output logic [15:0] address,
  output logic        we,
  output logic        re,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        halt
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ip;
  logic [15:0] r_acc;
  logic [15:0] r_a;
  logic [15:0] r_r;
  logic        r_borrow;

  logic [15:0] w_m;
  logic [15:0] w_r;
  logic        w_borrow;
  logic [15:0] w_address;
  logic        w_re;
  logic        w_we;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_is_in;
  logic        w_is_out;
  logic        w_mem_op;

`ifdef RSSB_IO_EN
  assign w_is_in  = (r_a == ADDR_IN);
  assign w_is_out = (r_a == ADDR_OUT);
`else
  logic w_unused;
  assign w_is_in  = 1'b0;
  assign w_is_out = 1'b0;
  assign w_unused = ^{in_data, in_valid};
`endif

  assign w_mem_op = !is_special(r_a) && !w_is_in && !w_is_out;

  rssb_alu u_alu (
    .m      (w_m),
    .acc    (r_acc),
    .r      (w_r),
    .borrow (w_borrow)
  );

  always_comb begin
    w_next      = r_state;
    w_re        = 1'b0;
    w_we        = 1'b0;
    w_address   = r_ip;
    w_m         = 16'h0000;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      FETCH: begin
        w_re   = 1'b1;
        w_next = (data == HALT_WORD) ? HALT : EXEC;
      end
      EXEC: begin
        w_next = WRITE;
        if (r_a == ADDR_IP) begin
          w_m = r_ip;
        end else if (r_a == ADDR_ACC) begin
          w_m = r_acc;
        end else if (r_a == ADDR_ZERO) begin
          w_m = 16'h0000;
        end else if (w_is_in) begin
          w_m        = in_data;
          w_in_ready = in_valid;
          if (!in_valid) w_next = EXEC;
        end else if (w_is_out) begin
          w_m = 16'h0000;
        end else begin
          w_re      = 1'b1;
          w_address = r_a;
          w_m       = data;
        end
      end
      WRITE: begin
        w_next      = FETCH;
        w_out_valid = w_is_out;
        if (w_mem_op) begin
          w_we      = 1'b1;
          w_address = r_a;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= FETCH;
      r_ip     <= RESET_IP;
      r_acc    <= 16'h0000;
      r_a      <= 16'h0000;
      r_r      <= 16'h0000;
      r_borrow <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        FETCH: r_a <= data;
        EXEC: begin
          r_r      <= w_r;
          r_borrow <= w_borrow;
        end
        WRITE: begin
          r_acc <= r_r;
          r_ip  <= (r_a == ADDR_IP) ? r_r : (r_ip + {15'd0, r_borrow} + 16'd1);
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by reset so an aborted WRITE never reaches memory.
  assign re        = w_re & ~reset;
  assign we        = w_we & ~reset;
  assign in_ready  = w_in_ready & ~reset;
  assign out_valid = w_out_valid & ~reset;
  assign out_data  = out_valid ? r_r : 16'h0000;
  assign address   = w_address;
  assign halt      = (r_state == HALT);
  assign data      = we ? r_r : 16'bz;

endmodule

`default_nettype wire
